uart_rx_fifo: RTL and testbench

//  Parametrised UART receiver, successor to the fixed 8N1 receiver on the host serial link.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/sync_fifo.sv | 45 ++++
 rtl/uart_rx_fifo.sv | 175 +++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types for the UART receive path: parity selection, receiver FSM states
// and the FIFO entry layout (data sized for the widest supported frame).
package uart_pkg;

  localparam int unsigned MAX_DATA_BITS = 9;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } rx_state_t;

  typedef struct packed {
    logic                     frame_err;
    logic                     parity_err;
    logic [MAX_DATA_BITS-1:0] data;
  } rx_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with wrap-bit pointers; head is visible combinationally.
// A push into a full FIFO succeeds only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter type T = logic [7:0]
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_push,
  input  T     i_data,
  input  logic i_pop,
  output T     o_data,
  output logic o_empty,
  output logic o_full
);

  localparam int unsigned AW = $clog2(DEPTH);

  T             r_mem [DEPTH];
  logic [AW:0]  r_wr;
  logic [AW:0]  r_rd;
  logic         w_do_pop;
  logic         w_do_push;

  assign o_empty   = (r_wr == r_rd);
  assign o_full    = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_data    = o_empty ? '0 : r_mem[r_rd[AW-1:0]];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + (AW+1)'(1);
      if (w_do_pop)  r_rd <= r_rd + (AW+1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// Parametrised UART receiver: synchroniser, mid-bit sampling FSM, error flags,
// sticky overrun and a small ready/valid receive FIFO.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DIV_WIDTH  = 12,
  parameter int unsigned DIVISOR    = 2604,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 in,
  output logic [DATA_BITS-1:0] out,
  output logic                 valid,
  input  logic                 ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  input  logic                 overrun_clr,
  output logic                 busy
);

  localparam parity_t              PAR       = parity_t'(2'(PARITY));
  localparam logic [DIV_WIDTH-1:0] HALF_LOAD = DIV_WIDTH'(DIVISOR / 2 - 1);
  localparam logic [DIV_WIDTH-1:0] FULL_LOAD = DIV_WIDTH'(DIVISOR - 1);
  localparam logic [3:0]           LAST_BIT  = 4'(DATA_BITS - 1);

  logic [1:0]           r_sync;
  rx_state_t            r_state;
  logic [DIV_WIDTH-1:0] r_cnt;
  logic [3:0]           r_bit;
  logic                 r_stop_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_frame_bad;
  logic                 r_parity_bad;
  logic                 r_overrun;

  logic                 w_rx_s;
  logic                 w_tick;
  logic                 w_last_stop;
  logic                 w_frame_bad_final;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_empty;
  logic                 w_full;
  rx_entry_t            w_entry;
  rx_entry_t            w_head;
  logic                 w_unused_head;

  assign w_rx_s            = r_sync[1];
  assign w_tick            = (r_cnt == '0);
  assign w_last_stop       = (STOP_BITS == 1) || r_stop_idx;
  assign w_frame_bad_final = r_frame_bad | ~w_rx_s;
  assign w_push            = (r_state == S_STOP) && w_tick && w_last_stop;
  assign w_pop             = valid && ready;

  always_comb begin
    w_entry                      = '0;
    w_entry.frame_err            = w_frame_bad_final;
    w_entry.parity_err           = r_parity_bad;
    w_entry.data[DATA_BITS-1:0]  = r_shift;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_sync <= '1;
    else     r_sync <= {r_sync[0], in};
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_bit        <= '0;
      r_stop_idx   <= 1'b0;
      r_shift      <= '0;
      r_frame_bad  <= 1'b0;
      r_parity_bad <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_rx_s) begin
            r_cnt   <= HALF_LOAD;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (!w_tick) begin
            r_cnt <= r_cnt - DIV_WIDTH'(1);
          end else if (w_rx_s) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt        <= FULL_LOAD;
            r_bit        <= '0;
            r_frame_bad  <= 1'b0;
            r_parity_bad <= 1'b0;
            r_state      <= S_DATA;
          end
        end
        S_DATA: begin
          if (!w_tick) begin
            r_cnt <= r_cnt - DIV_WIDTH'(1);
          end else begin
            r_cnt   <= FULL_LOAD;
            r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
            if (r_bit == LAST_BIT) begin
              r_stop_idx <= 1'b0;
              r_state    <= (PAR == PAR_NONE) ? S_STOP : S_PARITY;
            end else begin
              r_bit <= r_bit + 4'd1;
            end
          end
        end
        S_PARITY: begin
          if (!w_tick) begin
            r_cnt <= r_cnt - DIV_WIDTH'(1);
          end else begin
            r_cnt        <= FULL_LOAD;
            r_parity_bad <= ((^r_shift) ^ w_rx_s) != (PAR == PAR_ODD);
            r_state      <= S_STOP;
          end
        end
        S_STOP: begin
          if (!w_tick) begin
            r_cnt <= r_cnt - DIV_WIDTH'(1);
          end else if (w_last_stop) begin
            // All-zero data with a low stop bit is a line break; hold until the line recovers.
            r_cnt   <= '0;
            r_state <= (r_shift == '0 && w_frame_bad_final) ? S_BREAK : S_IDLE;
          end else begin
            r_cnt       <= FULL_LOAD;
            r_frame_bad <= w_frame_bad_final;
            r_stop_idx  <= 1'b1;
          end
        end
        S_BREAK: begin
          if (w_rx_s) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // A same-cycle set wins over the clear.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                             r_overrun <= 1'b0;
    else if (w_push && w_full && !w_pop) r_overrun <= 1'b1;
    else if (overrun_clr)                r_overrun <= 1'b0;
  end

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (rx_entry_t)
  ) u_fifo (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_push  (w_push),
    .i_data  (w_entry),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  assign valid         = !w_empty;
  assign out           = w_head.data[DATA_BITS-1:0];
  assign frame_err     = w_head.frame_err;
  assign parity_err    = w_head.parity_err;
  assign overrun       = r_overrun;
  assign busy          = (r_state != S_IDLE);
  assign w_unused_head = ^w_head.data;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench: two receivers (8N1 and 8E2, DIVISOR=16) fed directed serial frames.
module tb_uart_rx_fifo;

  localparam int BIT = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       line_a = 1'b1, ready_a = 1'b0, clr_a = 1'b0;
  logic [7:0] out_a;
  logic       valid_a, fe_a, pe_a, ovr_a, busy_a;
  logic       line_b = 1'b1, ready_b = 1'b0, clr_b = 1'b0;
  logic [7:0] out_b;
  logic       valid_b, fe_b, pe_b, ovr_b, busy_b;

  uart_rx_fifo #(
    .DIV_WIDTH(12), .DIVISOR(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) u_dut_a (
    .CLK(clk), .RST(rst), .in(line_a), .out(out_a), .valid(valid_a), .ready(ready_a),
    .frame_err(fe_a), .parity_err(pe_a), .overrun(ovr_a), .overrun_clr(clr_a), .busy(busy_a)
  );

  uart_rx_fifo #(
    .DIV_WIDTH(12), .DIVISOR(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)
  ) u_dut_b (
    .CLK(clk), .RST(rst), .in(line_b), .out(out_b), .valid(valid_b), .ready(ready_b),
    .frame_err(fe_b), .parity_err(pe_b), .overrun(ovr_b), .overrun_clr(clr_b), .busy(busy_b)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   rise_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t mk(input logic [7:0] d, input logic fe, input logic pe);
    exp_t e;
    e.d  = d;
    e.fe = fe;
    e.pe = pe;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input int which, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      if (which == 0) line_a = bits[i];
      else            line_b = bits[i];
      repeat (BIT) @(negedge clk);
    end
  endtask

  task automatic drain(input int which);
    int i;
    i = 0;
    while (((which == 0) ? q_a.size() : q_b.size()) > 0 && i < 3000) begin
      @(negedge clk);
      i++;
    end
    check((which == 0) ? "a_drain_left" : "b_drain_left",
          (which == 0) ? q_a.size() : q_b.size(), 0);
  endtask

  initial begin : mon_a
    exp_t e;
    logic pv;
    pv = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        if (valid_a && !pv && rise_cyc < 0) rise_cyc = cyc;
        pv = valid_a;
        if (valid_a && ready_a) begin
          if (q_a.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL a_unexpected: got out=0x%0h fe=%0b pe=%0b, expected no entry", out_a, fe_a, pe_a);
          end else begin
            e = q_a.pop_front();
            check("a_out", out_a, e.d);
            check("a_frame_err", fe_a, e.fe);
            check("a_parity_err", pe_a, e.pe);
          end
        end
      end
    end
  end

  initial begin : mon_b
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst && valid_b && ready_b) begin
        if (q_b.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL b_unexpected: got out=0x%0h fe=%0b pe=%0b, expected no entry", out_b, fe_b, pe_b);
        end else begin
          e = q_b.pop_front();
          check("b_out", out_b, e.d);
          check("b_frame_err", fe_b, e.fe);
          check("b_parity_err", pe_b, e.pe);
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected end of run");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int t0;
    logic [7:0] d;

    repeat (3) @(negedge clk);
    #1;
    check("rst_valid", valid_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_overrun", ovr_a, 0);
    check("rst_out", out_a, 0);
    check("rst_frame_err", fe_a, 0);
    check("rst_parity_err", pe_a, 0);
    check("rst_b_valid", valid_b, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // 8N1 0xA5 with latency check
    ready_a = 1'b1;
    q_a.push_back(mk(8'hA5, 1'b0, 1'b0));
    t0 = cyc;
    send_frame(0, {6'b0, 1'b1, 8'hA5, 1'b0}, 10);
    repeat (20) @(negedge clk);
    check("a_valid_latency", rise_cyc - t0, 155);
    check("a_busy_after_frame", busy_a, 0);

    // 5-cycle glitch on the idle line
    line_a = 1'b0;
    repeat (5) @(negedge clk);
    line_a = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("glitch_busy_mid", busy_a, 1);
    repeat (10) @(negedge clk);
    #1;
    check("glitch_busy_end", busy_a, 0);
    check("glitch_valid", valid_a, 0);

    // Five frames into a depth-4 FIFO with ready low
    ready_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      d = 8'(8'h11 * (i + 1));
      if (i < 4) q_a.push_back(mk(d, 1'b0, 1'b0));
      send_frame(0, {6'b0, 1'b1, d, 1'b0}, 10);
    end
    repeat (4) @(negedge clk);
    #1;
    check("ovr_set", ovr_a, 1);
    check("ovr_valid_held", valid_a, 1);
    @(negedge clk);
    clr_a = 1'b1;
    @(negedge clk);
    clr_a = 1'b0;
    #1;
    check("ovr_cleared", ovr_a, 0);

    // Sixth frame lands while full, with a pop in exactly the push cycle
    q_a.push_back(mk(8'h66, 1'b0, 1'b0));
    @(negedge clk);
    fork
      send_frame(0, {6'b0, 1'b1, 8'h66, 1'b0}, 10);
      begin
        repeat (154) @(negedge clk);
        ready_a = 1'b1;
        @(negedge clk);
        ready_a = 1'b0;
      end
    join
    repeat (4) @(negedge clk);
    #1;
    check("ovr_push_pop_full", ovr_a, 0);
    check("a_valid_after_6th", valid_a, 1);
    ready_a = 1'b1;
    drain(0);

    // Line break: 30 bit-times low
    q_a.push_back(mk(8'h00, 1'b1, 1'b0));
    line_a = 1'b0;
    repeat (30 * BIT) @(negedge clk);
    #1;
    check("break_busy", busy_a, 1);
    line_a = 1'b1;
    repeat (40) @(negedge clk);
    #1;
    check("break_idle", busy_a, 0);
    check("break_entries_left", q_a.size(), 0);

    // 8E2: parity and second stop bit
    ready_b = 1'b1;
    q_b.push_back(mk(8'h03, 1'b0, 1'b1));
    send_frame(1, {4'b0, 2'b11, 1'b1, 8'h03, 1'b0}, 12);
    q_b.push_back(mk(8'h03, 1'b0, 1'b0));
    send_frame(1, {4'b0, 2'b11, 1'b0, 8'h03, 1'b0}, 12);
    q_b.push_back(mk(8'h5A, 1'b1, 1'b0));
    send_frame(1, {4'b0, 1'b0, 1'b1, 1'b0, 8'h5A, 1'b0}, 12);
    line_b = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    drain(1);
    #1;
    check("b_busy_idle", busy_b, 0);

    // Reset mid-DATA flushes a held entry and the partial frame
    ready_b = 1'b0;
    send_frame(1, {4'b0, 2'b11, 1'b0, 8'h3C, 1'b0}, 12);
    #1;
    check("b_held_valid", valid_b, 1);
    line_b = 1'b0;
    repeat (BIT) @(negedge clk);
    line_b = 1'b1;
    repeat (BIT) @(negedge clk);
    line_b = 1'b0;
    repeat (BIT / 2) @(negedge clk);
    #1;
    check("b_busy_mid_data", busy_b, 1);
    rst = 1'b1;
    line_b = 1'b1;
    #1;
    check("b_rst_valid", valid_b, 0);
    check("b_rst_busy", busy_b, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    #1;
    check("b_post_rst_busy", busy_b, 0);
    check("b_post_rst_valid", valid_b, 0);
    ready_b = 1'b1;
    q_b.push_back(mk(8'h81, 1'b0, 1'b0));
    send_frame(1, {4'b0, 2'b11, 1'b0, 8'h81, 1'b0}, 12);
    drain(1);

    repeat (10) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
